// File: rtl/ps2_transmisor_if.sv
// Command/status handshake between a PS/2 host controller and ps2_transmisor.
interface ps2_transmisor_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
    modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_transmisor.sv
// Host-to-device PS/2 transmitter driving ps2c/ps2d open-drain (0 or Z).
// Define PS2_TX_ACK_CHECK_EN to sample the device ack bit and flag a missing ack on tx_err.
module ps2_transmisor #(
    parameter int RTS_CYCLES = 12000,
    parameter int FILTER_LEN = 8
) (
    input  logic            clk_nexys,
    input  logic            reset,
    ps2_transmisor_if.slave bus,
    inout  wire             ps2d,
    inout  wire             ps2c
);
    localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP
`ifdef PS2_TX_ACK_CHECK_EN
        , S_ACK
`endif
    } state_t;

    state_t                r_state, w_state_next;
    logic [FILTER_LEN-1:0] r_filter;
    logic                  r_fclk, w_fclk_next;
    logic [CW-1:0]         r_c, w_c_next;
    logic [3:0]            r_n, w_n_next;
    logic [8:0]            r_b, w_b_next;
    logic                  w_fall;
    logic                  w_ps2c_low, w_ps2d_low;
    logic                  w_done, w_idle;
`ifdef PS2_TX_ACK_CHECK_EN
    logic                  r_err, w_err_next;
`endif

    // The filtered clock only moves once the whole window agrees, so short glitches never toggle it.
    always_comb begin
        w_fclk_next = r_fclk;
        if (r_filter == {FILTER_LEN{1'b1}})      w_fclk_next = 1'b1;
        else if (r_filter == {FILTER_LEN{1'b0}}) w_fclk_next = 1'b0;
    end

    assign w_fall = r_fclk & ~w_fclk_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_nexys or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_filter <= '0;
            r_fclk   <= 1'b0;
            r_c      <= '0;
            r_n      <= '0;
            r_b      <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_filter <= {ps2c, r_filter[FILTER_LEN-1:1]};
            r_fclk   <= w_fclk_next;
            r_c      <= w_c_next;
            r_n      <= w_n_next;
            r_b      <= w_b_next;
`ifdef PS2_TX_ACK_CHECK_EN
            r_err    <= w_err_next;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_c_next     = r_c;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_ps2c_low   = 1'b0;
        w_ps2d_low   = 1'b0;
        w_done       = 1'b0;
        w_idle       = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
        w_err_next   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (bus.wr_ps2) begin
                    w_b_next     = {~^bus.din, bus.din};
                    w_c_next     = CW'(RTS_CYCLES - 1);
`ifdef PS2_TX_ACK_CHECK_EN
                    w_err_next   = 1'b0;
`endif
                    w_state_next = S_RTS;
                end
            end
            S_RTS: begin
                w_ps2c_low = 1'b1;
                if (r_c == '0) w_state_next = S_START;
                else           w_c_next     = r_c - 1'b1;
            end
            S_START: begin
                w_ps2d_low = 1'b1;
                if (w_fall) begin
                    w_n_next     = 4'd8;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_ps2d_low = ~r_b[0];
                if (w_fall) begin
                    w_b_next = {1'b0, r_b[8:1]};
                    if (r_n == 4'd0) w_state_next = S_STOP;
                    else             w_n_next     = r_n - 1'b1;
                end
            end
            S_STOP: begin
                if (w_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    w_state_next = S_ACK;
`else
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
`endif
                end
            end
`ifdef PS2_TX_ACK_CHECK_EN
            S_ACK: begin
                if (w_fall) begin
                    w_err_next   = ps2d;
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Line enables decode straight from state, so reset releases both lines without waiting for a clock.
    assign ps2c = w_ps2c_low ? 1'b0 : 1'bz;
    assign ps2d = w_ps2d_low ? 1'b0 : 1'bz;

    assign bus.tx_idle      = w_idle;
    assign bus.tx_done_tick = w_done;
`ifdef PS2_TX_ACK_CHECK_EN
    assign bus.tx_err       = r_err;
`else
    assign bus.tx_err       = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_transmisor.sv
// Directed bench for ps2_transmisor: a PS/2 device model clocks each frame and checks what it samples.
// Request-to-send is shortened through RTS_CYCLES so the whole run stays brief.
module tb_ps2_transmisor;
    localparam int RTS  = 1200;
    localparam int HALF = 40;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic NACK_ERR = 1'b1;
`else
    localparam logic NACK_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    wire  ps2c, ps2d;
    int   n_vec = 0;
    int   n_miss = 0;
    int   done_cnt = 0;

    ps2_transmisor_if bus ();

    ps2_transmisor #(.RTS_CYCLES(RTS), .FILTER_LEN(8)) dut (
        .clk_nexys (clk),
        .reset     (reset),
        .bus       (bus),
        .ps2d      (ps2d),
        .ps2c      (ps2c)
    );

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.tx_done_tick) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One host request plus device clocking; n_pulses < 12 stops the device early.
    task automatic send_frame(input string tag, input logic [7:0] byte_in, input logic exp_par,
                              input logic ack_bit, input logic exp_err, input int n_pulses,
                              input int inject_at, input int glitch_after);
        logic [10:0] exp_frame;
        logic [10:0] smp;
        int          low_cnt;
        int          t;
        int          done0;
        exp_frame = {1'b1, exp_par, byte_in, 1'b0};
        smp       = '0;
        done0     = done_cnt;
        // NOTE: stimulus is driven with blocking assignments on the falling edge, clear of the DUT's sampling edge.
        @(negedge clk); bus.wr_ps2 = 1'b1; bus.din = byte_in;
        @(negedge clk); bus.wr_ps2 = 1'b0;
        t = 0;
        while (ps2c === 1'b1 && t < 20) begin @(negedge clk); t++; end
        low_cnt = 0;
        while (ps2c === 1'b0 && low_cnt < RTS + 20) begin
            low_cnt++;
            if (low_cnt == 2) begin
                check({tag, "_busy_idle"}, 32'(bus.tx_idle), 32'd0);
                check({tag, "_err_clear"}, 32'(bus.tx_err), 32'd0);
            end
            if (low_cnt == inject_at) begin bus.wr_ps2 = 1'b1; bus.din = 8'h00; end
            else bus.wr_ps2 = 1'b0;
            @(negedge clk);
        end
        bus.wr_ps2 = 1'b0;
        check({tag, "_rts_len"}, 32'(low_cnt), 32'(RTS));
        check({tag, "_start_d"}, 32'(ps2d), 32'd0);
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= n_pulses; k++) begin
            if (k <= 11) smp[k-1] = ps2d;
            if (k == 12) dev_d_low = ~ack_bit;
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (k == glitch_after) begin
                repeat (15) @(negedge clk);
                check({tag, "_pre_glitch"}, 32'(ps2d), 32'(exp_frame[k]));
                dev_c_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (15) @(negedge clk);
                check({tag, "_post_glitch"}, 32'(ps2d), 32'(exp_frame[k]));
            end
            repeat (HALF) @(negedge clk);
            dev_d_low = 1'b0;
        end
        if (n_pulses >= 12) begin
            check({tag, "_frame"}, 32'(smp), 32'(exp_frame));
            check({tag, "_done_cnt"}, 32'(done_cnt - done0), 32'd1);
            check({tag, "_idle"}, 32'(bus.tx_idle), 32'd1);
            check({tag, "_err"}, 32'(bus.tx_err), 32'(exp_err));
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        #3 reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_idle", 32'(bus.tx_idle), 32'd1);
        check("rst_done", 32'(bus.tx_done_tick), 32'd0);
        check("rst_err",  32'(bus.tx_err), 32'd0);
        check("rst_ps2c", 32'(ps2c), 32'd1);
        check("rst_ps2d", 32'(ps2d), 32'd1);
        repeat (20) @(negedge clk);

        // 0xF4: five ones, parity 0.  0xFF: eight ones, parity 1.
        send_frame("f4",   8'hF4, 1'b0, 1'b0, 1'b0,     12, 0, 0);
        send_frame("ff",   8'hFF, 1'b1, 1'b0, 1'b0,     12, 0, 0);
        send_frame("nack", 8'hF4, 1'b0, 1'b1, NACK_ERR, 12, 0, 0);

        // After four clock falls the host is driving d3 of 0xF4, which is 0.
        send_frame("part", 8'hF4, 1'b0, 1'b0, 1'b0, 4, 0, 0);
        check("pre_rst_d",    32'(ps2d), 32'd0);
        check("pre_rst_idle", 32'(bus.tx_idle), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_ps2c", 32'(ps2c), 32'd1);
        check("mid_rst_ps2d", 32'(ps2d), 32'd1);
        check("mid_rst_idle", 32'(bus.tx_idle), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame("after_rst", 8'hF4, 1'b0, 1'b0, 1'b0, 12, 0, 0);

        send_frame("inject", 8'hF4, 1'b0, 1'b0, 1'b0, 12, 100, 0);
        // After the second fall the host shows d1 of 0xF4 (0); a false shift would show d2 (1).
        send_frame("glitch", 8'hF4, 1'b0, 1'b0, 1'b0, 12, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_transmisor.md
Name: ps2_transmisor

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xF4 enable, 0xFF reset) to a keyboard/mouse over the shared ps2c/ps2d lines.
- Sits beside the PS/2 receive path and shares the same physical pins.
- Drives each line only open-drain style (low or high-Z).
- The receive path must be ignored while tx_idle=0.

Parameters:
- RTS_CYCLES, 12000, clock cycles ps2c is held low for request-to-send (≥100 µs at 100 MHz).
- FILTER_LEN, 8, depth of the ps2c glitch filter shift register.

Ports:
- clk_nexys  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wr_ps2  input  1  start strobe, one cycle; accepted only when tx_idle=1
- din  input  8  byte to send, sampled on the accepted wr_ps2
- ps2d  inout  1  PS/2 data; driven 0 or released (Z)
- ps2c  inout  1  PS/2 clock; driven 0 or released (Z)
- tx_idle  output  1  high when in idle
- tx_done_tick  output  1  one-cycle pulse at end of frame
- tx_err  output  1  ack failure flag (see Optional Feature)

Behaviour:

Reset:
- State goes to idle; filter, filtered clock, counters and shift register go to 0.
- tx_idle=1, tx_done_tick=0, tx_err=0.
- Both lines are released immediately, because line enables decode combinationally from state.

Clock filter:
- ps2c is shifted into a FILTER_LEN-bit register every cycle.
- Filtered clock goes to 1 when the register is all ones, to 0 when all zeros, and otherwise holds.
- fall_edge = filtered_reg & ~filtered_next.

Frame format:
- b_reg[8:0] = {odd parity (~^din), din}, shifted out LSB first.
- Frame is start bit 0, din[0..7], parity, then stop (line released).

FSM:
- idle:
  - tx_idle=1; both lines released.
  - On wr_ps2: load b_reg, load c_reg=RTS_CYCLES-1, clear tx_err, go to rts.
- rts:
  - ps2c driven 0; c_reg decrements each cycle.
  - At c_reg==0 go to start. ps2c is held low exactly RTS_CYCLES cycles.
- start:
  - ps2c released; ps2d driven 0.
  - On fall_edge: n_reg=8, go to data.
- data:
  - ps2d driven 0 when b_reg[0]=0, released when b_reg[0]=1.
  - On fall_edge: b_reg shifts right (zero fill).
  - If n_reg==0 go to stop, else n_reg-1. This gives 9 bits total.
- stop:
  - Both lines released.
  - On fall_edge: go to ack (feature on), or pulse tx_done_tick and go to idle (feature off).
- ack (feature on only):
  - Both lines released.
  - On fall_edge: sample ps2d; tx_err<=ps2d; pulse tx_done_tick; go to idle.

Boundary conditions:
- wr_ps2 while not idle: ignored; din is not re-sampled.
- wr_ps2 coincident with tx_done_tick: ignored, since the state is not yet idle.
- Reset in any state: lines are released in the same cycle, and the FSM restarts in idle.
- A glitch on ps2c shorter than FILTER_LEN cycles produces no fall_edge.
- Any fall_edge seen while in idle or rts is ignored.
- No timeout exists: a missing device stalls the FSM in start/data/stop until reset.

Optional Feature:
- Macro: PS2_TX_ACK_CHECK_EN.
- Defined:
  - The ack state is present.
  - After the stop bit, the device's ack bit is sampled on the next fall_edge.
  - ps2d=1 (no ack) sets tx_err=1. tx_err stays high until the next accepted wr_ps2 or reset.
  - tx_done_tick is issued at the ack edge.
- Undefined:
  - No ack state exists; the FSM returns to idle at the stop-bit fall_edge with tx_done_tick.
  - tx_err is tied to 0.

Test Plan:
1. wr_ps2 with din=0xF4, device model clocking at 12.5 kHz:
   - ps2c is low for exactly 12000 cycles.
   - Then ps2d=0 with ps2c released.
   - Device samples 0,0,1,0,1,1,1,1, parity 0, stop 1.
   - Device acks 0 → tx_done_tick once, tx_err=0, tx_idle=1.
2. din=0xFF → data bits all 1, parity bit 1. Same done timing as scenario 1.
3. PS2_TX_ACK_CHECK_EN defined, device leaves ps2d high in the ack slot:
   - tx_err=1 after done.
   - Next wr_ps2 clears tx_err.
4. Reset asserted in data after 4 bits:
   - ps2c and ps2d both Z in the same cycle; tx_idle=1.
   - A new wr_ps2 with 0xF4 then completes correctly.
5. Pulse wr_ps2 with din=0x00 during rts of a 0xF4 transfer → the transmitted byte remains 0xF4.
6. 5-cycle low glitch on ps2c during data → no bit shift. A following valid edge shifts exactly one bit.
